// File: rtl/config_pkg.sv
// Shared types for the UART ALU command master: operation codes, wire opcodes
// and the master state encoding.
package config_pkg;

  typedef enum logic [1:0] {
    ECHO = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DIV  = 2'd3
  } alu_op_t;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAF;
  localparam logic [7:0] OP_DIV  = 8'hF6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_OP,
    ST_HDR_RSV,
    ST_HDR_LSB,
    ST_HDR_MSB,
    ST_PAYLOAD,
    ST_RESP,
    ST_ECHO_DRAIN
  } state_t;

  function automatic logic [7:0] op_byte(alu_op_t op);
    case (op)
      ECHO:    return OP_ECHO;
      ADD:     return OP_ADD;
      MUL:     return OP_MUL;
      default: return OP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/alu_resp_assembler.sv
// Collects RX bytes LSB first into 32-bit words and holds one finished word
// behind a valid/ready interface; clr_i drops any partial or held word.
module alu_resp_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_data_o
);

  logic [1:0]  cnt_q;
  logic [23:0] part_q;
  logic [31:0] hold_q;
  logic        hold_valid_q;
  logic        byte_hs;

  // A byte may enter while the held word is leaving in the same cycle.
  assign byte_ready_o = !hold_valid_q || word_ready_i;
  assign byte_hs      = byte_valid_i && byte_ready_o;
  assign word_valid_o = hold_valid_q;
  assign word_data_o  = hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      part_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      if (hold_valid_q && word_ready_i) hold_valid_q <= 1'b0;
      if (byte_hs) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          hold_q       <= {byte_data_i, part_q};
          hold_valid_q <= 1'b1;
        end else begin
          part_q <= {byte_data_i, part_q[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/alu_cmd_master.sv
// Host-side initiator for the UART ALU packet protocol: serializes a command to
// TX bytes and returns RX result words. Optional RX timeout: ALU_CMD_MASTER_TIMEOUT_EN.
module alu_cmd_master
  import config_pkg::*;
#(
  parameter int COUNT_W    = 8,
  parameter int DATA_WIDTH = 8
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1 << 20
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [COUNT_W-1:0]    cmd_words_i,
  input  logic                  opnd_valid_i,
  output logic                  opnd_ready_o,
  input  logic [31:0]           opnd_data_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [31:0]           res_data_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  res_last_o,
  output logic                  busy_o,
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  output logic                  timeout_o,
`endif
  output logic                  err_o
);

  if (DATA_WIDTH != 8) begin : g_dw_check
    $error("alu_cmd_master: DATA_WIDTH must be 8");
  end
  if (COUNT_W > 13) begin : g_cw_check
    $error("alu_cmd_master: COUNT_W must be <= 13");
  end

  state_t               state_q, state_d;
  alu_op_t              op_q;
  logic [COUNT_W-1:0]   n_q, tx_words_q, rx_words_q;
  logic [15:0]          len_q;
  logic [31:0]          shift_q;
  logic [2:0]           sh_cnt_q;
  logic                 err_q;
  logic                 cmd_hs, cmd_bad, tx_hs, opnd_hs, tx_last;
  logic                 res_hs, res_last_hs, rx_window;
  logic                 asm_byte_valid, asm_byte_ready, asm_clr;
  logic                 to_hit;

  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign cmd_bad     = (cmd_words_i == '0) ||
                       ((alu_op_t'(cmd_op_i) == DIV) && (cmd_words_i != COUNT_W'(2)));
  assign tx_hs       = tx_valid_o && tx_ready_i;
  assign opnd_hs     = opnd_valid_i && opnd_ready_o;
  assign tx_last     = (state_q == ST_PAYLOAD) && tx_hs && (sh_cnt_q == 3'd1) &&
                       (tx_words_q == n_q);
  assign res_hs      = res_valid_o && res_ready_i;
  assign res_last_hs = res_hs && res_last_o;
  assign res_last_o  = res_valid_o && ((op_q != ECHO) || (rx_words_q == n_q - COUNT_W'(1)));
  assign err_o       = err_q;

  // Echoed bytes flow back while the payload is still going out.
  assign rx_window      = ((state_q == ST_PAYLOAD) && (op_q == ECHO)) ||
                          (state_q == ST_RESP) || (state_q == ST_ECHO_DRAIN);
  assign asm_byte_valid = rx_valid_i && rx_window;
  assign asm_clr        = (state_q == ST_IDLE) || to_hit;
  assign rx_ready_o     = (state_q == ST_IDLE) || (rx_window && asm_byte_ready);

  alu_resp_assembler u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_byte_valid),
    .byte_ready_o (asm_byte_ready),
    .byte_data_i  (rx_data_i),
    .word_valid_o (res_valid_o),
    .word_ready_i (res_ready_i),
    .word_data_o  (res_data_o)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d      = state_q;
    cmd_ready_o  = 1'b0;
    opnd_ready_o = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = shift_q[7:0];
    busy_o       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o      = 1'b0;
        cmd_ready_o = 1'b1;
        if (cmd_hs && !cmd_bad) state_d = ST_HDR_OP;
      end
      ST_HDR_OP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = op_byte(op_q);
        if (tx_hs) state_d = ST_HDR_RSV;
      end
      ST_HDR_RSV: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h00;
        if (tx_hs) state_d = ST_HDR_LSB;
      end
      ST_HDR_LSB: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[7:0];
        if (tx_hs) state_d = ST_HDR_MSB;
      end
      ST_HDR_MSB: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[15:8];
        if (tx_hs) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        tx_valid_o   = (sh_cnt_q != 3'd0);
        opnd_ready_o = (sh_cnt_q == 3'd0) && (tx_words_q != n_q);
        if (tx_last) begin
          if (op_q != ECHO)                             state_d = ST_RESP;
          else if ((rx_words_q == n_q) || res_last_hs)  state_d = ST_IDLE;
          else                                          state_d = ST_ECHO_DRAIN;
        end
      end
      ST_RESP, ST_ECHO_DRAIN: begin
        if (res_last_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (to_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      op_q       <= ECHO;
      n_q        <= '0;
      len_q      <= '0;
      tx_words_q <= '0;
      rx_words_q <= '0;
      shift_q    <= '0;
      sh_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      err_q   <= (cmd_hs && cmd_bad) || to_hit;
      if (cmd_hs && !cmd_bad) begin
        op_q       <= alu_op_t'(cmd_op_i);
        n_q        <= cmd_words_i;
        len_q      <= (16'(cmd_words_i) << 2) + 16'd4;
        tx_words_q <= '0;
        rx_words_q <= '0;
        sh_cnt_q   <= '0;
      end
      if (opnd_hs) begin
        shift_q    <= opnd_data_i;
        sh_cnt_q   <= 3'd4;
        tx_words_q <= tx_words_q + COUNT_W'(1);
      end else if ((state_q == ST_PAYLOAD) && tx_hs) begin
        shift_q  <= {8'h00, shift_q[31:8]};
        sh_cnt_q <= sh_cnt_q - 3'd1;
      end
      if (res_hs) rx_words_q <= rx_words_q + COUNT_W'(1);
    end
  end

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_q, awaiting;

  // Only count while the block is starved for RX, not while a result is held.
  assign awaiting  = ((state_q == ST_RESP) || (state_q == ST_ECHO_DRAIN)) && !res_valid_o;
  assign to_hit    = awaiting && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign timeout_o = to_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_q <= to_hit;
      if (!awaiting || to_hit || (asm_byte_valid && asm_byte_ready)) to_cnt_q <= '0;
      else                                                            to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed self-checking bench for alu_cmd_master: packet bytes, result words,
// rejects, back-pressure, mid-packet reset and (when enabled) the RX timeout.
module tb_alu_cmd_master;
  import config_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_words;
  logic        opnd_valid, opnd_ready;
  logic [31:0] opnd_data;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] res_data;
  logic        res_valid, res_ready, res_last, busy, err;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  logic        timeout;
  int          to_pulses = 0, to_err = 0;
`endif

  int          n_checks = 0, n_fail = 0;
  logic [7:0]  tx_log[$], exp_tx[$], rx_q[$];
  logic [32:0] res_log[$], exp_res[$];
  logic        echo_mode = 1'b0, tx_rand = 1'b0, res_rand = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_master #(
    .COUNT_W     (8),
    .DATA_WIDTH  (8)
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (64)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_words_i  (cmd_words),
    .opnd_valid_i (opnd_valid),
    .opnd_ready_o (opnd_ready),
    .opnd_data_i  (opnd_data),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .res_data_o   (res_data),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_last_o   (res_last),
    .busy_o       (busy),
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    .timeout_o    (timeout),
`endif
    .err_o        (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_hdr(input logic [7:0] opb, input logic [15:0] len);
    exp_tx.push_back(opb);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(len[7:0]);
    exp_tx.push_back(len[15:8]);
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  // Stimulus drivers change inputs only on the falling edge.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    res_ready = 1'b1;
    forever begin
      @(negedge clk);
      res_ready = res_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rx_q.size() > 0) begin
        rx_valid = 1'b1;
        rx_data  = rx_q[0];
      end else begin
        rx_valid = 1'b0;
      end
    end
  end

  // Handshake monitor; the remote echoes payload bytes one cycle after TX.
  always @(posedge clk) begin
    if (rx_valid && rx_ready && rx_q.size() > 0) void'(rx_q.pop_front());
    if (tx_valid && tx_ready) begin
      if (echo_mode && tx_log.size() >= 4) rx_q.push_back(tx_data);
      tx_log.push_back(tx_data);
    end
    if (res_valid && res_ready) res_log.push_back({res_last, res_data});
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    if (timeout) to_pulses++;
    if (timeout && err) to_err++;
`endif
  end

  task automatic run_cmd(input string tag, input logic [1:0] op, input int n,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic bad, input logic push_resp, input logic [31:0] resp);
    logic [31:0] w[4];
    int          cyc;
    logic        got;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    tx_log.delete();
    res_log.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_words = 8'(n);
    cyc = 0;
    do begin
      @(posedge clk);
      got = cmd_ready;
      cyc++;
    end while (!got && cyc < 100);
    if (!got) check({tag, "_cmd_hs_timeout"}, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_err"}, err, bad);
    if (bad) begin
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      @(negedge clk);
      check({tag, "_err_pulse_end"}, err, 0);
      repeat (4) @(negedge clk);
      check({tag, "_tx_count"}, tx_log.size(), 0);
      check({tag, "_busy"}, busy, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      opnd_valid = 1'b1;
      opnd_data  = w[i];
      cyc = 0;
      do begin
        @(posedge clk);
        got = opnd_ready;
        cyc++;
      end while (!got && cyc < 200);
      if (!got) check({tag, "_opnd_hs_timeout"}, 0, 1);
      @(negedge clk);
      opnd_valid = 1'b0;
    end
    if (push_resp) for (int i = 0; i < 4; i++) rx_q.push_back(resp[8*i +: 8]);
    cyc = 0;
    while ((busy || res_log.size() < exp_res.size()) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_tx[i]);
    check({tag, "_res_count"}, res_log.size(), exp_res.size());
    for (int i = 0; i < exp_res.size() && i < res_log.size(); i++)
      check($sformatf("%s_res%0d", tag, i), res_log[i], exp_res[i]);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_rx_drained"}, rx_q.size(), 0);
  endtask

  initial begin
    int cyc;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_words  = 8'd0;
    opnd_valid = 1'b0;
    opnd_data  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_opnd_ready", opnd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray RX byte in IDLE is swallowed without producing a result.
    rx_q.push_back(8'h55);
    repeat (3) @(negedge clk);
    check("stray_dropped", rx_q.size(), 0);
    check("stray_no_res", res_valid, 0);

    exp_tx.delete(); exp_res.delete();
    put_hdr(8'hAD, 16'h000C); put_word(32'h00000005); put_word(32'h00000007);
    exp_res.push_back({1'b1, 32'h0000000C});
    run_cmd("add", ADD, 2, 32'h5, 32'h7, 0, 0, 1'b0, 1'b1, 32'h0000000C);

    exp_tx.delete(); exp_res.delete();
    put_hdr(8'hAF, 16'h000C); put_word(32'hFFFFFFFD); put_word(32'h00000004);
    exp_res.push_back({1'b1, 32'hFFFFFFF4});
    run_cmd("mul", MUL, 2, 32'hFFFFFFFD, 32'h4, 0, 0, 1'b0, 1'b1, 32'hFFFFFFF4);

    exp_tx.delete(); exp_res.delete();
    put_hdr(8'hEC, 16'h000C); put_word(32'hDEADBEEF); put_word(32'h01020304);
    exp_res.push_back({1'b0, 32'hDEADBEEF});
    exp_res.push_back({1'b1, 32'h01020304});
    echo_mode = 1'b1;
    run_cmd("echo", ECHO, 2, 32'hDEADBEEF, 32'h01020304, 0, 0, 1'b0, 1'b0, 0);
    echo_mode = 1'b0;

    exp_tx.delete(); exp_res.delete();
    run_cmd("div_n3", DIV, 3, 1, 2, 3, 0, 1'b1, 1'b0, 0);
    run_cmd("add_n0", ADD, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);

    // ECHO N=4 with random TX and result back-pressure.
    exp_tx.delete(); exp_res.delete();
    put_hdr(8'hEC, 16'h0014);
    put_word(32'h11223344); put_word(32'h55667788);
    put_word(32'h99AABBCC); put_word(32'hDDEEFF00);
    exp_res.push_back({1'b0, 32'h11223344});
    exp_res.push_back({1'b0, 32'h55667788});
    exp_res.push_back({1'b0, 32'h99AABBCC});
    exp_res.push_back({1'b1, 32'hDDEEFF00});
    echo_mode = 1'b1; tx_rand = 1'b1; res_rand = 1'b1;
    run_cmd("echo_bp", ECHO, 4, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
            1'b0, 1'b0, 0);
    echo_mode = 1'b0; tx_rand = 1'b0; res_rand = 1'b0;

    // Reset in the middle of the payload.
    tx_log.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_words = 8'd2;
    @(negedge clk);
    cmd_valid  = 1'b0;
    opnd_valid = 1'b1; opnd_data = 32'h11111111;
    cyc = 0;
    while (tx_log.size() < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_payload", tx_log.size() >= 5, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_opnd_ready", opnd_ready, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_rx_ready", rx_ready, 1);
    opnd_valid = 1'b0;
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_tx.delete(); exp_res.delete();
    put_hdr(8'hAD, 16'h0008); put_word(32'h0000002A);
    exp_res.push_back({1'b1, 32'h0000002A});
    run_cmd("add_n1", ADD, 1, 32'h2A, 0, 0, 0, 1'b0, 1'b1, 32'h0000002A);

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    exp_tx.delete(); exp_res.delete();
    put_hdr(8'hAD, 16'h0008); put_word(32'h00000009);
    run_cmd("timeout", ADD, 1, 32'h9, 0, 0, 0, 1'b0, 1'b0, 0);
    check("timeout_pulses", to_pulses, 1);
    check("timeout_with_err", to_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
